alu_decode: RTL
===============

Name: alu_decode

Overview:
- Decode/issue stage for the RV32I integer ALU. Accepts one instruction per handshake, along with its register operands and PC.
- Produces a registered ALU operation (x, y, ctrl, alt) plus writeback tag (rd, we), using a valid/ready handshake toward execute.
- ctrl uses the ALU encoding: 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
- alt selects the sub/sra variant.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  instruction and operands valid.
- in_ready  out  1  stage can accept.
- instr  in  32  instruction word.
- pc  in  32  instruction address.
- rs1_data  in  32  register-file value for instr[19:15].
- rs2_data  in  32  register-file value for instr[24:20].
- out_valid  out  1  issued op valid.
- out_ready  in  1  execute accepts.
- x  out  32  ALU operand x.
- y  out  32  ALU operand y.
- ctrl  out  3  ALU op.
- alt  out  1  sub/sra variant select.
- rd  out  5  destination register.
- we  out  1  writeback enable (0 when rd==0 or instruction illegal).
- illegal  out  1  issued op was illegal.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.
- trap  out  1  sticky trap flag; only present with ALU_DECODE_TRAP_EN, tied 0 otherwise.
- trap_clr  in  1  clears trap; ignored without the macro.

Behaviour:
- Reset values: out_valid=0, x=0, y=0, ctrl=0, alt=0, rd=0, we=0, illegal=0, illegal_cnt=0, trap=0.
- Reset takes effect in the same edge even mid-handshake; an in-flight op is dropped.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register, no bubble under back-pressure).
  - An accept occurs on an edge where in_valid && in_ready; the output register loads the decode of that instruction.
  - Latency is 1 cycle from accept to out_valid.
  - If out_valid && out_ready && !in_valid, out_valid clears.
  - Output fields stay stable while out_valid && !out_ready.
- Decode on opcode instr[6:0]:
  - OP (0110011): x=rs1_data, y=rs2_data, ctrl=funct3, alt=instr[30].
    - Legal only if instr[31:25] is 0000000, or 0100000 with funct3 in {000,101}.
  - OP-IMM (0010011): x=rs1_data, ctrl=funct3.
    - Legal forms:
      - funct3 001 requires instr[31:25]=0000000.
      - funct3 101 requires instr[31:25] in {0000000, 0100000}; alt=instr[30].
      - All other funct3: alt=0.
    - y = sign-extended instr[31:20]; for shifts y = zero-extended instr[24:20].
  - LUI (0110111): x=0, y={instr[31:12],12'b0}, ctrl=000, alt=0.
  - AUIPC (0010111): x=pc, y={instr[31:12],12'b0}, ctrl=000, alt=0.
- Any other opcode, or an illegal field combination:
  - illegal=1, we=0, x=y=0, ctrl=000, alt=0.
  - rd still equals instr[11:7].
- rd=instr[11:7] always; we=legal && rd!=0.
- illegal_cnt increments by 1 per accepted illegal instruction and saturates at all-ones.

Optional Feature:
- Macro ALU_DECODE_TRAP_EN.
- Defined: a two-state FSM, RUN and TRAP.
  - RUN -> TRAP on the accept of an illegal instruction; trap=1 in TRAP.
  - In TRAP, in_ready=0. The already-registered illegal op still drains normally.
  - TRAP -> RUN on trap_clr=1.
  - If trap_clr and an illegal accept occur on the same edge, the result is TRAP (the illegal accept wins).
  - Reset enters RUN.
- Undefined: there is no FSM and trap is tied 0. Illegal instructions pass through as NOPs (we=0, illegal=1) and the stream never stalls.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3) with rs1=5, rs2=7: next cycle out_valid=1, x=5, y=7, ctrl=000, alt=0, rd=3, we=1.
- sub x3,x1,x2 (0x402081B3) followed by srai x4,x1,3 (0x4030D213), rs1=0xFFFFFFF0: first op ctrl=000 alt=1; second op ctrl=101, alt=1, y=3.
- addi x0,x0,-1 (0xFFF00013): y=0xFFFFFFFF, we=0, illegal=0. Then auipc x5,0x12345 at pc=0x100: x=0x100, y=0x12345000, ctrl=000.
- Hold out_ready=0 for 3 cycles with in_valid=1 on back-to-back instructions: in_ready=0 after the first accept, outputs stable, no instruction lost or duplicated once out_ready=1.
- Opcode 0x7F, and slli with instr[31:25]=0100000: illegal=1, we=0, illegal_cnt increments by 1 each. With the macro: trap=1, in_ready=0 until trap_clr is pulsed, and the simultaneous trap_clr plus illegal accept edge stays in TRAP.
- 260 illegal accepts with CNT_W=8: illegal_cnt stops at 255. Assert rst while out_valid=1: next cycle all outputs at their reset values.

Source files
------------

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - RV32I ALU decode/issue stage; optional sticky trap under ALU_DECODE_TRAP_EN
module alu_decode #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  x,
   output logic [XLEN-1:0]  y,
   output logic [2:0]       ctrl,
   output logic             alt,
   output logic [4:0]       rd,
   output logic             we,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt,
   output logic             trap,
   input  logic             trap_clr
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] F7_ZERO   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic            dec_legal;
   logic [XLEN-1:0] dec_x;
   logic [XLEN-1:0] dec_y;
   logic [2:0]      dec_ctrl;
   logic            dec_alt;
   logic            accept;
   logic            stall;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Decode the presented instruction; anything illegal collapses to a zeroed NOP
   always_comb begin
      dec_legal = 1'b0;
      dec_x     = '0;
      dec_y     = '0;
      dec_ctrl  = 3'b000;
      dec_alt   = 1'b0;
      case (opcode)
         OPC_OP: begin
            if (funct7 == F7_ZERO ||
                (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
               dec_legal = 1'b1;
               dec_x     = rs1_data;
               dec_y     = rs2_data;
               dec_ctrl  = funct3;
               dec_alt   = instr[30];
            end
         end
         OPC_IMM: begin
            case (funct3)
               3'b001: begin
                  if (funct7 == F7_ZERO) begin
                     dec_legal = 1'b1;
                     dec_x     = rs1_data;
                     dec_y     = {{(XLEN-5){1'b0}}, instr[24:20]};
                     dec_ctrl  = funct3;
                  end
               end
               3'b101: begin
                  if (funct7 == F7_ZERO || funct7 == F7_ALT) begin
                     dec_legal = 1'b1;
                     dec_x     = rs1_data;
                     dec_y     = {{(XLEN-5){1'b0}}, instr[24:20]};
                     dec_ctrl  = funct3;
                     dec_alt   = instr[30];
                  end
               end
               default: begin
                  dec_legal = 1'b1;
                  dec_x     = rs1_data;
                  dec_y     = {{(XLEN-12){instr[31]}}, instr[31:20]};
                  dec_ctrl  = funct3;
               end
            endcase
         end
         OPC_LUI: begin
            dec_legal = 1'b1;
            dec_y     = {instr[31:12], 12'b0};
         end
         OPC_AUIPC: begin
            dec_legal = 1'b1;
            dec_x     = pc;
            dec_y     = {instr[31:12], 12'b0};
         end
         default: begin
            dec_legal = 1'b0;
         end
      endcase
   end

   assign in_ready = (!out_valid || out_ready) && !stall;
   assign accept   = in_valid && in_ready;

`ifdef ALU_DECODE_TRAP_EN
   typedef enum logic {ST_RUN, ST_TRAP} state_t;
   state_t state_q, state_d;

   // Trap FSM next state; an illegal accept takes priority over a same-edge clear
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (accept && !dec_legal) state_d = ST_TRAP;
         ST_TRAP: if (trap_clr)             state_d = ST_RUN;
      endcase
   end

   // Trap state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   assign trap  = (state_q == ST_TRAP);
   assign stall = trap;
`else
   logic unused_trap_clr;
   assign unused_trap_clr = trap_clr;
   assign trap  = 1'b0;
   assign stall = 1'b0;
`endif

   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  x_q, x_d, y_q, y_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic             alt_q, alt_d, we_q, we_d, illegal_q, illegal_d;
   logic [4:0]       rd_q, rd_d;
   logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

   // Output register next state: load on accept, drop valid when consumed, otherwise hold
   always_comb begin
      out_valid_d   = out_valid_q;
      x_d           = x_q;
      y_d           = y_q;
      ctrl_d        = ctrl_q;
      alt_d         = alt_q;
      rd_d          = rd_q;
      we_d          = we_q;
      illegal_d     = illegal_q;
      illegal_cnt_d = illegal_cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         x_d         = dec_x;
         y_d         = dec_y;
         ctrl_d      = dec_ctrl;
         alt_d       = dec_alt;
         rd_d        = instr[11:7];
         we_d        = dec_legal && (instr[11:7] != 5'd0);
         illegal_d   = !dec_legal;
         if (!dec_legal && illegal_cnt_q != {CNT_W{1'b1}})
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         ctrl_q        <= 3'b000;
         alt_q         <= 1'b0;
         rd_q          <= 5'd0;
         we_q          <= 1'b0;
         illegal_q     <= 1'b0;
         illegal_cnt_q <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         x_q           <= x_d;
         y_q           <= y_d;
         ctrl_q        <= ctrl_d;
         alt_q         <= alt_d;
         rd_q          <= rd_d;
         we_q          <= we_d;
         illegal_q     <= illegal_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign x           = x_q;
   assign y           = y_q;
   assign ctrl        = ctrl_q;
   assign alt         = alt_q;
   assign rd          = rd_q;
   assign we          = we_q;
   assign illegal     = illegal_q;
   assign illegal_cnt = illegal_cnt_q;

endmodule
